tc_bus_arbiter: RTL and testbench
=================================

// Module: tc_bus_arbiter
// PURPOSE
//  Shares one pipelined TC bus master port between NUM_REQ upstream requesters.
//  Grants one request at a time and holds the grant until the downstream tc_aack.
//  Stops issuing new requests while MAX_PEND transactions are outstanding.
//  Routes each in-order tc_rack/tc_wack back to the requester that issued the transaction.
//  Sits between the client ports and the TC bus target, on the clk_bus domain.
// PARAMETERS
//  NUM_REQ    4  number of upstream requesters (2..8)
//  TC_AWIDTH  8  address width
//  TC_DWIDTH  8  data width
//  MAX_PEND   4  max outstanding (read+write) transactions on the bus
// PORTS
//  clk_bus   in   1                  bus clock
//  rst       in   1                  synchronous, active-high reset
//  m_req     in   NUM_REQ            per-requester request
//  m_rnw     in   NUM_REQ            per-requester read(1)/write(0)
//  m_addr    in   NUM_REQ*TC_AWIDTH  flattened addresses; requester i at [i*TC_AWIDTH +: TC_AWIDTH]
//  m_wdata   in   NUM_REQ*TC_DWIDTH  flattened write data; requester i at [i*TC_DWIDTH +: TC_DWIDTH]
//  m_aack    out  NUM_REQ            address accepted, one-hot pulse
//  m_rack    out  NUM_REQ            read data valid, one-hot pulse
//  m_wack    out  NUM_REQ            write done, one-hot pulse
//  m_rdata   out  TC_DWIDTH          read data, broadcast to all requesters; qualified by m_rack
//  tc_req    out  1                  downstream request
//  tc_rnw, tc_addr, tc_wdata  out    downstream command fields of the granted requester
//  tc_aack, tc_rack, tc_wack  in  1  downstream acknowledges
//  tc_rdata  in   TC_DWIDTH          downstream read data, valid with tc_rack
//  tc_err    out  1                  sticky protocol-error flag
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, both ID FIFOs empty, rd/wr counts=0.
//    All outputs are 0 while rst is high and in the first cycle after rst.
//  - FSM IDLE:
//    - If any m_req and (rd_cnt+wr_cnt) < MAX_PEND: register the winner id.
//    - Go to BUSY.
//  - FSM BUSY:
//    - tc_req=1; tc_rnw/addr/wdata are driven from the granted requester.
//    - Grant is locked, so the downstream request is held stable until tc_aack.
//    - On tc_aack: go to IDLE.
//    - Timing: m_req at N -> tc_req at N+1 earliest; aack at M -> next tc_req at M+2 earliest.
//  - m_aack[g] = tc_aack & tc_req, combinational pass-through to the granted requester g.
//  - Upstream requesters must hold m_req/m_rnw/m_addr/m_wdata stable until m_aack.
//  - tc_aack while tc_req=0 (speculative) is ignored: no push, no m_aack.
//  - Accepted read: push g into the read ID FIFO (depth MAX_PEND).
//  - Accepted write: push g into the write ID FIFO.
//  - tc_rack: pop the read FIFO head h; m_rack[h]=1; m_rdata=tc_rdata, same cycle.
//    - tc_rack never completes a read in its own aack cycle.
//  - tc_wack, write FIFO non-empty: pop head h; m_wack[h]=1.
//  - tc_wack, write FIFO empty, write accepted this same cycle: bypass.
//    m_wack[g]=1 and no push.
//  - Push and pop in one cycle: count unchanged; the FIFO pointers wrap modulo MAX_PEND.
//  - Responses are strictly in issue order within each type. Reads and writes are independent.
//  - tc_err (set, held until rst), on any of:
//    - tc_rack with the read FIFO empty;
//    - tc_wack with no pending or bypass write;
//    - tc_aack accepted with (rd_cnt+wr_cnt)==MAX_PEND.
//    The offending response is dropped: no m_* pulse.
//  - rst mid-transaction: all pending state is discarded. Late tc_rack/tc_wack after reset set tc_err.
// CONFIGURATION
//  TC_ARB_FIXED_PRIO_EN
//  - Defined: fixed priority, lowest index wins.
//  - Undefined: round-robin. Search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1.
// STRUCTURE
//  - Package tc_arb_pkg: state enum {IDLE,BUSY}; ID_W=$clog2(NUM_REQ) function;
//    MAX_PEND default; flatten-index helper functions.
//  - Sub-module tc_id_fifo (depth MAX_PEND, width ID_W, push/pop/count/head).
//    Instantiated twice: read FIFO and write FIFO.
// TESTING
//  1. Reqs 0 and 2 both raise reads, round-robin -> tc_req grants 0 then 2.
//     Each m_aack is one-hot. tc_addr holds until tc_aack.
//  2. Four accepted reads, no racks -> fifth m_req[1] is not issued (tc_req=0).
//     One tc_rack -> tc_req rises 2 cycles later.
//  3. Reads from 3,1,3; racks return 0xA1,0xB2,0xC3 -> m_rack goes to 3,1,3 in that order,
//     with m_rdata 0xA1,0xB2,0xC3.
//  4. Write from 2 with tc_aack and tc_wack in the same cycle -> m_aack[2] and m_wack[2]
//     in that cycle; write count stays 0.
//  5. tc_rack with no pending read -> tc_err=1, no m_rack; it holds until rst. Likewise speculative
//     tc_aack with tc_req=0 -> no m_aack, no pending count change.
//  6. Assert rst with 2 reads pending -> counts 0; a tc_rack afterwards sets tc_err.
//     Rerun test 1 with TC_ARB_FIXED_PRIO_EN -> requester 0 always wins.

Source files
------------

// File: rtl/tc_arb_pkg.sv
// Shared types and helpers for the TC bus arbiter.
// Build option: TC_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package tc_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam int MAX_PEND_DEF = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int flat_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/tc_id_fifo.sv
// Small in-order FIFO of requester ids; tracks who owns each outstanding bus transaction.
module tc_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [W-1:0]                   push_data,
  input  logic                           pop,
  output logic [W-1:0]                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push = push && ((cnt_q != FULL) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/tc_bus_arbiter.sv
// Shares one pipelined TC bus master port between NUM_REQ requesters and routes acks back.
// Build option: TC_ARB_FIXED_PRIO_EN selects fixed lowest-index priority; default is round-robin.
module tc_bus_arbiter
  import tc_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TC_AWIDTH = 8,
  parameter int TC_DWIDTH = 8,
  parameter int MAX_PEND  = MAX_PEND_DEF
) (
  input  logic                           clk_bus,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             m_req,
  input  logic [NUM_REQ-1:0]             m_rnw,
  input  logic [NUM_REQ*TC_AWIDTH-1:0]   m_addr,
  input  logic [NUM_REQ*TC_DWIDTH-1:0]   m_wdata,
  output logic [NUM_REQ-1:0]             m_aack,
  output logic [NUM_REQ-1:0]             m_rack,
  output logic [NUM_REQ-1:0]             m_wack,
  output logic [TC_DWIDTH-1:0]           m_rdata,
  output logic                           tc_req,
  output logic                           tc_rnw,
  output logic [TC_AWIDTH-1:0]           tc_addr,
  output logic [TC_DWIDTH-1:0]           tc_wdata,
  input  logic                           tc_aack,
  input  logic                           tc_rack,
  input  logic                           tc_wack,
  input  logic [TC_DWIDTH-1:0]           tc_rdata,
  output logic                           tc_err
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W:0]       PEND_LIM = (CNT_W + 1)'(MAX_PEND);
  localparam logic [NUM_REQ-1:0]   ONE      = NUM_REQ'(1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              err_q, err_d;
  logic              act_q;

  logic              en, live;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt;
  logic [CNT_W:0]    pend;
  logic [ID_W-1:0]   rd_head, wr_head, win;
  logic              found;
  int                idx;

  logic                  g_rnw;
  logic [TC_AWIDTH-1:0]  g_addr;
  logic [TC_DWIDTH-1:0]  g_wdata;

  logic acc, full_err, acc_ok, wr_acc;
  logic rd_push, rd_pop, rack_err;
  logic wr_push, wr_pop, wr_byp, wack_err;

  // Outputs stay quiet during reset and the cycle right after it.
  assign en   = act_q & ~rst;
  assign live = ~rst;
  assign pend = {1'b0, rd_cnt} + {1'b0, wr_cnt};

  always_comb begin
    g_rnw   = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        g_rnw   = m_rnw[i];
        g_addr  = m_addr[flat_lo(i, TC_AWIDTH) +: TC_AWIDTH];
        g_wdata = m_wdata[flat_lo(i, TC_DWIDTH) +: TC_DWIDTH];
      end
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef TC_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(last_q) + 1 + k) % NUM_REQ;
`endif
      if (!found && m_req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign tc_req   = en & (state_q == BUSY);
  assign tc_rnw   = tc_req & g_rnw;
  assign tc_addr  = tc_req ? g_addr  : '0;
  assign tc_wdata = tc_req ? g_wdata : '0;

  assign acc      = tc_req & tc_aack;
  assign full_err = acc & (pend == PEND_LIM);
  assign acc_ok   = acc & ~full_err;
  assign rd_push  = acc_ok & g_rnw;
  assign wr_acc   = acc_ok & ~g_rnw;

  // A read is never completed by the rack of its own acceptance cycle.
  assign rd_pop   = live & tc_rack & (rd_cnt != '0);
  assign rack_err = live & tc_rack & (rd_cnt == '0);

  assign wr_pop   = live & tc_wack & (wr_cnt != '0);
  assign wr_byp   = live & tc_wack & (wr_cnt == '0) & wr_acc;
  assign wack_err = live & tc_wack & (wr_cnt == '0) & ~wr_acc;
  assign wr_push  = wr_acc & ~wr_byp;

  assign m_aack  = acc_ok ? (ONE << grant_q) : '0;
  assign m_rack  = (en & rd_pop) ? (ONE << rd_head) : '0;
  assign m_rdata = (en & rd_pop) ? tc_rdata : '0;
  assign m_wack  = (en & wr_pop) ? (ONE << wr_head) :
                   (en & wr_byp) ? (ONE << grant_q) : '0;
  assign tc_err  = err_q & ~rst;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q | rack_err | wack_err | full_err;
    case (state_q)
      IDLE: begin
        if (en && found && (pend < PEND_LIM)) begin
          grant_d = win;
          last_d  = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      err_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      act_q   <= 1'b1;
    end
  end

  tc_id_fifo #(.DEPTH(MAX_PEND), .W(ID_W)) u_rd_fifo (
    .clk       (clk_bus),
    .rst       (rst),
    .push      (rd_push),
    .push_data (grant_q),
    .pop       (rd_pop),
    .head      (rd_head),
    .count     (rd_cnt)
  );

  tc_id_fifo #(.DEPTH(MAX_PEND), .W(ID_W)) u_wr_fifo (
    .clk       (clk_bus),
    .rst       (rst),
    .push      (wr_push),
    .push_data (grant_q),
    .pop       (wr_pop),
    .head      (wr_head),
    .count     (wr_cnt)
  );

endmodule

// File: tb/tb_tc_bus_arbiter.sv
// Directed bench for tc_bus_arbiter (4 requesters, 8-bit address/data, 4 outstanding).
module tb_tc_bus_arbiter;

  logic        clk_bus = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  m_req = '0, m_rnw = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_aack, m_rack, m_wack;
  logic [7:0]  m_rdata;
  logic        tc_req, tc_rnw;
  logic [7:0]  tc_addr, tc_wdata;
  logic        tc_aack = 1'b0, tc_rack = 1'b0, tc_wack = 1'b0;
  logic [7:0]  tc_rdata = '0;
  logic        tc_err;

  int total = 0;
  int bad   = 0;

  always #5 clk_bus = ~clk_bus;

  tc_bus_arbiter dut (
    .clk_bus  (clk_bus),
    .rst      (rst),
    .m_req    (m_req),
    .m_rnw    (m_rnw),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_aack   (m_aack),
    .m_rack   (m_rack),
    .m_wack   (m_wack),
    .m_rdata  (m_rdata),
    .tc_req   (tc_req),
    .tc_rnw   (tc_rnw),
    .tc_addr  (tc_addr),
    .tc_wdata (tc_wdata),
    .tc_aack  (tc_aack),
    .tc_rack  (tc_rack),
    .tc_wack  (tc_wack),
    .tc_rdata (tc_rdata),
    .tc_err   (tc_err)
  );

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  // Raise one request, wait (bounded) for the grant, accept it for one cycle.
  task automatic issue(input int id, input bit rnw, input logic [7:0] addr,
                       input logic [7:0] wd, output bit ok, output logic [3:0] ak);
    m_req[id]            = 1'b1;
    m_rnw[id]            = rnw;
    m_addr[id*8 +: 8]    = addr;
    m_wdata[id*8 +: 8]   = wd;
    ok = 1'b0;
    ak = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (tc_req === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      tc_aack = 1'b1;
      #1;
      ak = m_aack;
      tick();
      tc_aack = 1'b0;
    end
    m_req[id] = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tc_rack = 1'b1; tc_rdata = 8'hFF; m_req = 4'b1111;
    #1;
    total++; if (m_rack !== 4'b0000 || m_rdata !== 8'h00) begin bad++; $display("FAIL rst_rack: got %b/%h want 0000/00", m_rack, m_rdata); end
    total++; if (tc_req !== 1'b0 || tc_err !== 1'b0 || m_aack !== 4'b0000) begin bad++; $display("FAIL rst_out: got req=%b err=%b aack=%b want 0/0/0000", tc_req, tc_err, m_aack); end
    tick();
    rst = 1'b0; tc_rack = 1'b0; m_req = 4'b0000;
    #1;
    total++; if (tc_req !== 1'b0 || m_wack !== 4'b0000 || tc_addr !== 8'h00) begin bad++; $display("FAIL rst_first: got req=%b wack=%b addr=%h want 0/0000/00", tc_req, m_wack, tc_addr); end
    tick();
    tick();
    total++; if (tc_err !== 1'b0 || tc_req !== 1'b0) begin bad++; $display("FAIL rst_idle: got err=%b req=%b want 0/0", tc_err, tc_req); end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_g2;
    logic [7:0] exp_a2;
`ifdef TC_ARB_FIXED_PRIO_EN
    exp_g2 = 4'b0001; exp_a2 = 8'h10;
`else
    exp_g2 = 4'b0100; exp_a2 = 8'h20;
`endif
    m_rnw = 4'b0101; m_addr = 32'h0020_0010; m_req = 4'b0101;
    #1;
    total++; if (tc_req !== 1'b0) begin bad++; $display("FAIL arb_idle: got %b want 0", tc_req); end
    tick();
    total++; if (tc_req !== 1'b1 || tc_addr !== 8'h10 || tc_rnw !== 1'b1) begin bad++; $display("FAIL arb_g1: got req=%b addr=%h rnw=%b want 1/10/1", tc_req, tc_addr, tc_rnw); end
    tick();
    tc_aack = 1'b1;
    #1;
    total++; if (tc_addr !== 8'h10 || m_aack !== 4'b0001) begin bad++; $display("FAIL arb_hold: got addr=%h aack=%b want 10/0001", tc_addr, m_aack); end
    tick();
    tc_aack = 1'b0;
    #1;
    total++; if (tc_req !== 1'b0 || m_aack !== 4'b0000) begin bad++; $display("FAIL arb_gap: got req=%b aack=%b want 0/0000", tc_req, m_aack); end
    tick();
    total++; if (tc_req !== 1'b1 || tc_addr !== exp_a2) begin bad++; $display("FAIL arb_g2: got req=%b addr=%h want 1/%h", tc_req, tc_addr, exp_a2); end
    tc_aack = 1'b1;
    #1;
    total++; if (m_aack !== exp_g2) begin bad++; $display("FAIL arb_aack2: got %b want %b", m_aack, exp_g2); end
    tick();
    tc_aack = 1'b0; m_req = 4'b0000; tc_rack = 1'b1; tc_rdata = 8'h55;
    #1;
    total++; if (m_rack !== 4'b0001 || m_rdata !== 8'h55) begin bad++; $display("FAIL arb_rack1: got %b/%h want 0001/55", m_rack, m_rdata); end
    tick();
    tc_rdata = 8'h66;
    #1;
    total++; if (m_rack !== exp_g2 || m_rdata !== 8'h66) begin bad++; $display("FAIL arb_rack2: got %b/%h want %b/66", m_rack, m_rdata, exp_g2); end
    tick();
    tc_rack = 1'b0;
    #1;
    total++; if (m_rack !== 4'b0000 || tc_err !== 1'b0) begin bad++; $display("FAIL arb_done: got rack=%b err=%b want 0000/0", m_rack, tc_err); end
  endtask

  task automatic test_max_pend();
    bit ok, seen;
    logic [3:0] ak;
    logic [3:0] exp_r [4];
    exp_r[0] = 4'b0001; exp_r[1] = 4'b0001; exp_r[2] = 4'b0001; exp_r[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 8'h30 + 8'(i), 8'h00, ok, ak);
      total++; if (!ok || ak !== 4'b0001) begin bad++; $display("FAIL mp_issue%0d: got ok=%b aack=%b want 1/0001", i, ok, ak); end
    end
    m_req[1] = 1'b1; m_rnw[1] = 1'b1; m_addr[15:8] = 8'h3F;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tc_req !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mp_block: got tc_req seen=%b want 0", seen); end
    tc_rack = 1'b1; tc_rdata = 8'h01;
    #1;
    total++; if (m_rack !== 4'b0001) begin bad++; $display("FAIL mp_rack: got %b want 0001", m_rack); end
    tick();
    tc_rack = 1'b0;
    #1;
    total++; if (tc_req !== 1'b0) begin bad++; $display("FAIL mp_plus1: got %b want 0", tc_req); end
    tick();
    total++; if (tc_req !== 1'b1 || tc_addr !== 8'h3F) begin bad++; $display("FAIL mp_plus2: got req=%b addr=%h want 1/3f", tc_req, tc_addr); end
    tc_aack = 1'b1;
    #1;
    total++; if (m_aack !== 4'b0010) begin bad++; $display("FAIL mp_aack: got %b want 0010", m_aack); end
    tick();
    tc_aack = 1'b0; m_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tc_rack = 1'b1; tc_rdata = 8'(i);
      #1;
      total++; if (m_rack !== exp_r[i]) begin bad++; $display("FAIL mp_drain%0d: got %b want %b", i, m_rack, exp_r[i]); end
      tick();
    end
    tc_rack = 1'b0;
  endtask

  task automatic test_order();
    bit ok;
    logic [3:0] ak;
    logic [3:0] exp_r [3];
    logic [7:0] dat [3];
    int ids [3];
    ids[0] = 3; ids[1] = 1; ids[2] = 3;
    exp_r[0] = 4'b1000; exp_r[1] = 4'b0010; exp_r[2] = 4'b1000;
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      issue(ids[i], 1'b1, 8'h70 + 8'(i), 8'h00, ok, ak);
      total++; if (!ok || ak !== exp_r[i]) begin bad++; $display("FAIL ord_issue%0d: got ok=%b aack=%b want 1/%b", i, ok, ak, exp_r[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      tc_rack = 1'b1; tc_rdata = dat[i];
      #1;
      total++; if (m_rack !== exp_r[i] || m_rdata !== dat[i]) begin bad++; $display("FAIL ord_rack%0d: got %b/%h want %b/%h", i, m_rack, m_rdata, exp_r[i], dat[i]); end
      tick();
    end
    tc_rack = 1'b0;
  endtask

  task automatic test_write_bypass();
    bit ok;
    logic [3:0] ak;
    m_req[2] = 1'b1; m_rnw[2] = 1'b0; m_addr[23:16] = 8'h44; m_wdata[23:16] = 8'h5A;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (tc_req === 1'b1) ok = 1'b1;
    end
    total++; if (!ok || tc_rnw !== 1'b0 || tc_wdata !== 8'h5A || tc_addr !== 8'h44) begin bad++; $display("FAIL wb_cmd: got ok=%b rnw=%b wd=%h addr=%h want 1/0/5a/44", ok, tc_rnw, tc_wdata, tc_addr); end
    tc_aack = 1'b1; tc_wack = 1'b1;
    #1;
    total++; if (m_aack !== 4'b0100 || m_wack !== 4'b0100) begin bad++; $display("FAIL wb_same: got aack=%b wack=%b want 0100/0100", m_aack, m_wack); end
    tick();
    tc_aack = 1'b0; tc_wack = 1'b0; m_req[2] = 1'b0;
    #1;
    total++; if (m_wack !== 4'b0000) begin bad++; $display("FAIL wb_after: got %b want 0000", m_wack); end
    issue(1, 1'b0, 8'h55, 8'h66, ok, ak);
    total++; if (!ok || ak !== 4'b0010) begin bad++; $display("FAIL wb_issue: got ok=%b aack=%b want 1/0010", ok, ak); end
    tc_wack = 1'b1;
    #1;
    total++; if (m_wack !== 4'b0010) begin bad++; $display("FAIL wb_next: got %b want 0010", m_wack); end
    tick();
    tc_wack = 1'b0;
    #1;
    total++; if (tc_err !== 1'b0) begin bad++; $display("FAIL wb_err: got %b want 0", tc_err); end
  endtask

  task automatic test_errors();
    tc_rack = 1'b1; tc_rdata = 8'h77;
    #1;
    total++; if (m_rack !== 4'b0000 || m_rdata !== 8'h00) begin bad++; $display("FAIL err_rack: got %b/%h want 0000/00", m_rack, m_rdata); end
    tick();
    tc_rack = 1'b0;
    #1;
    total++; if (tc_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", tc_err); end
    tc_aack = 1'b1;
    #1;
    total++; if (m_aack !== 4'b0000) begin bad++; $display("FAIL err_spec_aack: got %b want 0000", m_aack); end
    tick();
    tc_aack = 1'b0; tc_rack = 1'b1;
    #1;
    total++; if (m_rack !== 4'b0000) begin bad++; $display("FAIL err_spec_push: got %b want 0000", m_rack); end
    tick();
    tc_rack = 1'b0;
    tick();
    tick();
    total++; if (tc_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", tc_err); end
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    logic [3:0] ak;
    do_reset();
    total++; if (tc_err !== 1'b0) begin bad++; $display("FAIL rm_clear: got %b want 0", tc_err); end
    issue(1, 1'b1, 8'h81, 8'h00, ok, ak);
    issue(1, 1'b1, 8'h82, 8'h00, ok, ak);
    rst = 1'b1; tc_rack = 1'b1; tc_rdata = 8'h99;
    #1;
    total++; if (m_rack !== 4'b0000 || tc_err !== 1'b0) begin bad++; $display("FAIL rm_inrst: got rack=%b err=%b want 0000/0", m_rack, tc_err); end
    tick();
    tick();
    rst = 1'b0; tc_rack = 1'b0;
    tick();
    tick();
    tc_rack = 1'b1;
    #1;
    total++; if (m_rack !== 4'b0000) begin bad++; $display("FAIL rm_late_rack: got %b want 0000", m_rack); end
    tick();
    tc_rack = 1'b0;
    #1;
    total++; if (tc_err !== 1'b1) begin bad++; $display("FAIL rm_late_err: got %b want 1", tc_err); end
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(3, 1'b1, 8'h90 + 8'(i), 8'h00, ok, ak);
      if (!ok || ak !== 4'b1000) all_ok = 1'b0;
    end
    total++; if (all_ok !== 1'b1) begin bad++; $display("FAIL rm_counts: four reads accepted=%b want 1", all_ok); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_max_pend();
    test_order();
    test_write_bypass();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
